// File: rtl/fir_pilote.sv
// Host-side controller for a FIR core: loads coefficients, buffers samples in a small
// FIFO, and sends them one at a time to the FIR. It captures the result, or flags a timeout.
module fir_pilote #(
    parameter int ordreFir   = 10,
    parameter int N          = 16,
    parameter int PROFONDEUR = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] coef_in,
    input  logic         coef_valid,
    output logic         coef_ready,
    input  logic         coef_debut,
    input  logic [N-1:0] ech_in,
    input  logic         ech_valid,
    output logic         ech_ready,
    output logic [N-1:0] g0,
    output logic [7:0]   waddrRAMCoef,
    output logic         ecritRAM_coef,
    output logic [N-1:0] entree_fir,
    output logic         nouvel_echantillon,
    input  logic [N-1:0] sortie_fir,
    input  logic         traitement_fini,
    output logic [N-1:0] res_out,
    output logic         res_valid,
    output logic         coefs_charges,
    output logic         erreur_timeout
);

    localparam int PW = (PROFONDEUR > 1) ? $clog2(PROFONDEUR) : 1;
    localparam int CW = $clog2(PROFONDEUR + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0] LAST_ADDR = 8'(ordreFir - 1);

    typedef enum logic [1:0] {REPOS = 2'd0, ENVOI = 2'd1, ATTENTE = 2'd2} etat_t;

    etat_t         state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic          charges_q, charges_d;
    logic [N-1:0]  g0_q, g0_d;
    logic [7:0]    waddr_q, waddr_d;
    logic          ecrit_q, ecrit_d;
    logic          coef_ready_q, coef_ready_d;
    logic [N-1:0]  mem_q [PROFONDEUR];
    logic [N-1:0]  mem_d [PROFONDEUR];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ech_ready_q, ech_ready_d;
    logic [N-1:0]  entree_q, entree_d;
    logic          nouvel_q, nouvel_d;
    logic [N-1:0]  res_q, res_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          coef_acc_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    waddr_sel_s;

    assign coef_acc_s  = coef_valid && coef_ready_q;
    assign push_s      = ech_valid && ech_ready_q;
    assign pop_s       = (state_q == ENVOI);
    assign waddr_sel_s = coef_debut ? 8'd0 : addr_q;

    // Next-state logic: coefficient path, sample FIFO and transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        charges_d   = charges_q;
        g0_d        = g0_q;
        waddr_d     = waddr_q;
        ecrit_d     = 1'b0;
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        entree_d    = entree_q;
        nouvel_d    = 1'b0;
        res_d       = res_q;
        res_valid_d = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;

        if (coef_acc_s) begin
            g0_d    = coef_in;
            waddr_d = waddr_sel_s;
            ecrit_d = 1'b1;
            if (waddr_sel_s == LAST_ADDR) begin
                addr_d    = 8'd0;
                charges_d = 1'b1;
            end else begin
                addr_d    = waddr_sel_s + 8'd1;
                charges_d = coef_debut ? 1'b0 : charges_q;
            end
        end else if (coef_debut) begin
            addr_d    = 8'd0;
            charges_d = 1'b0;
        end else begin
            addr_d = addr_q;
        end

        if (push_s) begin
            mem_d[wptr_q] = ech_in;
            wptr_d = (wptr_q == PW'(PROFONDEUR - 1)) ? {PW{1'b0}} : wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = (rptr_q == PW'(PROFONDEUR - 1)) ? {PW{1'b0}} : rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        count_d = count_q + CW'(push_s) - CW'(pop_s);

        case (state_q)
            REPOS: begin
                if ((count_q != {CW{1'b0}}) && charges_q && !coef_acc_s) begin
                    state_d = ENVOI;
                end else begin
                    state_d = REPOS;
                end
            end
            ENVOI: begin
                entree_d = mem_q[rptr_q];
                nouvel_d = 1'b1;
                cnt_d    = {TW{1'b0}};
                state_d  = ATTENTE;
            end
            ATTENTE: begin
                // cnt_q == 0 marks the strobe cycle, where a done pulse cannot yet be ours.
                if (traitement_fini && (cnt_q != {TW{1'b0}})) begin
                    res_d       = sortie_fir;
                    res_valid_d = 1'b1;
                    state_d     = REPOS;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = REPOS;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = REPOS;
            end
        endcase

        if (coef_debut) begin
            err_d = 1'b0;
        end else begin
            err_d = err_d;
        end

        ech_ready_d  = (count_d != CW'(PROFONDEUR));
        coef_ready_d = (state_d == REPOS);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= REPOS;
            addr_q       <= 8'd0;
            charges_q    <= 1'b0;
            g0_q         <= {N{1'b0}};
            waddr_q      <= 8'd0;
            ecrit_q      <= 1'b0;
            coef_ready_q <= 1'b1;
            wptr_q       <= {PW{1'b0}};
            rptr_q       <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
            ech_ready_q  <= 1'b1;
            entree_q     <= {N{1'b0}};
            nouvel_q     <= 1'b0;
            res_q        <= {N{1'b0}};
            res_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= {TW{1'b0}};
            for (int i = 0; i < PROFONDEUR; i++) begin
                mem_q[i] <= {N{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            charges_q    <= charges_d;
            g0_q         <= g0_d;
            waddr_q      <= waddr_d;
            ecrit_q      <= ecrit_d;
            coef_ready_q <= coef_ready_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            ech_ready_q  <= ech_ready_d;
            entree_q     <= entree_d;
            nouvel_q     <= nouvel_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < PROFONDEUR; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign coef_ready         = coef_ready_q;
    assign ech_ready          = ech_ready_q;
    assign g0                 = g0_q;
    assign waddrRAMCoef       = waddr_q;
    assign ecritRAM_coef      = ecrit_q;
    assign entree_fir         = entree_q;
    assign nouvel_echantillon = nouvel_q;
    assign res_out            = res_q;
    assign res_valid          = res_valid_q;
    assign coefs_charges      = charges_q;
    assign erreur_timeout     = err_q;

endmodule
